// File: rtl/perf_trace_tx.sv
// perf_trace_tx: streams retire-event trace records through a small FIFO,
// then emits seven performance-counter summary records once the core halts.
module perf_trace_tx #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ev_regwrite,
   input  logic [2:0]  ev_wreg,
   input  logic [15:0] ev_wdata,
   input  logic        ev_memread,
   input  logic        ev_memwrite,
   input  logic [15:0] ev_maddr,
   input  logic [15:0] ev_mdin,
   input  logic [15:0] ev_mdout,
   input  logic        ev_halt,
   input  logic        ev_icreq,
   input  logic        ev_ichit,
   input  logic        ev_dcreq,
   input  logic        ev_dchit,
   input  logic        tr_ready,
   output logic        tr_valid,
   output logic        tr_kind,
   output logic [55:0] tr_payload,
   output logic        overflow,
   output logic        done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] BODY_MAX = (AW+1)'(FIFO_DEPTH - 1);
   localparam logic [2:0] LAST_IDX = 3'd6;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      SUMMARY,
      DONE
   } state_t;

   state_t state;
   state_t stateNext;

   logic [55:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic [AW:0]   bodyCnt;
   logic [AW:0]   cntInc;
   logic [AW:0]   cntDec;

   logic        evAny;
   logic        pushReq;
   logic        push;
   logic        drop;
   logic        pop;
   logic        full;
   logic        headLoad;
   logic        bodyEmpty;
   logic        bodyWr;
   logic        bodyRd;
   logic        sumStart;
   logic [55:0] evPayload;

   logic [2:0]  sumIdx;
   logic [2:0]  nextIdx;
   logic [31:0] sumValue;
   logic [55:0] sumPayload;

   logic [31:0] cycleCnt;
   logic [31:0] instCnt;
   logic [31:0] icReq;
   logic [31:0] icHit;
   logic [31:0] dcReq;
   logic [31:0] dcHit;
   logic [31:0] dropCnt;

   assign evAny   = ev_regwrite | ev_memread | ev_memwrite | ev_halt;
   assign pushReq = (state == RUN) && evAny;
   assign pop     = tr_valid && tr_ready;

   // Head register plus body together hold FIFO_DEPTH records.
   assign bodyEmpty = (bodyCnt == '0);
   assign full      = tr_valid && (bodyCnt == BODY_MAX);
   assign push      = pushReq && (!full || pop);
   assign drop      = pushReq && !push;
   assign headLoad  = !tr_valid || pop;

   assign bodyRd = (state == RUN || state == DRAIN) && headLoad && !bodyEmpty;
   assign bodyWr = push && !(headLoad && bodyEmpty);
   assign cntInc = {{AW{1'b0}}, bodyWr};
   assign cntDec = {{AW{1'b0}}, bodyRd};

   assign sumStart = (state == DRAIN) && !tr_valid && bodyEmpty;
   assign done     = (state == DONE);

   always_comb begin
      evPayload     = '0;
      evPayload[55] = ev_regwrite;
      evPayload[54] = ev_memread;
      evPayload[53] = ev_memwrite;
      evPayload[52] = ev_halt;
      if (ev_regwrite) begin
         evPayload[50:48] = ev_wreg;
         evPayload[47:32] = ev_wdata;
      end
      if (ev_memread || ev_memwrite) begin
         evPayload[31:16] = ev_maddr;
      end
      if (ev_memwrite) begin
         evPayload[15:0] = ev_mdin;
      end else if (ev_memread) begin
         evPayload[15:0] = ev_mdout;
      end
   end

   always_comb begin
      nextIdx  = (state == SUMMARY) ? sumIdx + 3'd1 : 3'd0;
      sumValue = dropCnt;
      unique case (nextIdx)
         3'd0:    sumValue = cycleCnt;
         3'd1:    sumValue = instCnt;
         3'd2:    sumValue = icReq;
         3'd3:    sumValue = icHit;
         3'd4:    sumValue = dcReq;
         3'd5:    sumValue = dcHit;
         default: sumValue = dropCnt;
      endcase
      sumPayload = {5'b0, nextIdx, 16'b0, sumValue};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         RUN: begin
            if (ev_halt) stateNext = DRAIN;
         end
         DRAIN: begin
            if (sumStart) stateNext = SUMMARY;
         end
         SUMMARY: begin
            if (pop && sumIdx == LAST_IDX) stateNext = DONE;
         end
         DONE: begin
            stateNext = DONE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycleCnt <= '0;
         instCnt  <= '0;
         icReq    <= '0;
         icHit    <= '0;
         dcReq    <= '0;
         dcHit    <= '0;
         dropCnt  <= '0;
         overflow <= 1'b0;
      end else begin
         if (state == RUN) begin
            cycleCnt <= cycleCnt + 32'd1;
            if (ev_regwrite | ev_memwrite | ev_halt) instCnt <= instCnt + 32'd1;
            if (ev_icreq) icReq <= icReq + 32'd1;
            if (ev_ichit) icHit <= icHit + 32'd1;
            if (ev_dcreq) dcReq <= dcReq + 32'd1;
            if (ev_dchit) dcHit <= dcHit + 32'd1;
            if (drop) dropCnt <= dropCnt + 32'd1;
         end
         if (drop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (bodyWr) mem[wrPtr] <= evPayload;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr      <= '0;
         rdPtr      <= '0;
         bodyCnt    <= '0;
         tr_valid   <= 1'b0;
         tr_kind    <= 1'b0;
         tr_payload <= '0;
         sumIdx     <= '0;
      end else begin
         if (bodyWr) wrPtr <= wrPtr + AW'(1);
         if (bodyRd) rdPtr <= rdPtr + AW'(1);
         bodyCnt <= bodyCnt + cntInc - cntDec;
         unique case (state)
            RUN, DRAIN: begin
               if (sumStart) begin
                  tr_valid   <= 1'b1;
                  tr_kind    <= 1'b1;
                  tr_payload <= sumPayload;
                  sumIdx     <= 3'd0;
               end else if (headLoad) begin
                  if (bodyRd) begin
                     tr_valid   <= 1'b1;
                     tr_payload <= mem[rdPtr];
                  end else if (push) begin
                     tr_valid   <= 1'b1;
                     tr_payload <= evPayload;
                  end else begin
                     tr_valid   <= 1'b0;
                     tr_payload <= '0;
                  end
               end
            end
            SUMMARY: begin
               if (pop) begin
                  if (sumIdx == LAST_IDX) begin
                     tr_valid   <= 1'b0;
                     tr_kind    <= 1'b0;
                     tr_payload <= '0;
                  end else begin
                     sumIdx     <= nextIdx;
                     tr_payload <= sumPayload;
                  end
               end
            end
            DONE: begin
               tr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_perf_trace_tx.sv
// Self-checking bench for perf_trace_tx: scoreboard of expected records
// filled as events are driven, drained by a negedge handshake monitor.
module tb_perf_trace_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        ev_regwrite = 1'b0;
   logic [2:0]  ev_wreg = '0;
   logic [15:0] ev_wdata = '0;
   logic        ev_memread = 1'b0;
   logic        ev_memwrite = 1'b0;
   logic [15:0] ev_maddr = '0;
   logic [15:0] ev_mdin = '0;
   logic [15:0] ev_mdout = '0;
   logic        ev_halt = 1'b0;
   logic        ev_icreq = 1'b0;
   logic        ev_ichit = 1'b0;
   logic        ev_dcreq = 1'b0;
   logic        ev_dchit = 1'b0;
   logic        tr_ready = 1'b0;
   logic        tr_valid;
   logic        tr_kind;
   logic [55:0] tr_payload;
   logic        overflow;
   logic        done;

   int errors = 0;
   int checks = 0;

   logic [56:0] expQ [$];
   logic [31:0] mCycle, mInst, mIcReq, mIcHit, mDcReq, mDcHit, mDrop;
   bit          mRun;

   perf_trace_tx #(.FIFO_DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .ev_regwrite(ev_regwrite), .ev_wreg(ev_wreg), .ev_wdata(ev_wdata),
      .ev_memread(ev_memread), .ev_memwrite(ev_memwrite),
      .ev_maddr(ev_maddr), .ev_mdin(ev_mdin), .ev_mdout(ev_mdout),
      .ev_halt(ev_halt), .ev_icreq(ev_icreq), .ev_ichit(ev_ichit),
      .ev_dcreq(ev_dcreq), .ev_dchit(ev_dchit), .tr_ready(tr_ready),
      .tr_valid(tr_valid), .tr_kind(tr_kind), .tr_payload(tr_payload),
      .overflow(overflow), .done(done)
   );

   always #5 clk = ~clk;

   logic [56:0] held;
   logic [56:0] expRec;
   bit          stalled = 0;

   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         stalled = 0;
      end else begin
         if (stalled) begin
            checks++;
            if (tr_valid !== 1'b1 || {tr_kind, tr_payload} !== held) begin
               errors++;
               $display("FAIL stable: got v=%b rec=%h want v=1 rec=%h",
                        tr_valid, {tr_kind, tr_payload}, held);
            end
         end
         stalled = 0;
         if (tr_valid === 1'b1) begin
            if (tr_ready) begin
               checks++;
               if (expQ.size() == 0) begin
                  errors++;
                  $display("FAIL record: got %h want none", {tr_kind, tr_payload});
               end else begin
                  expRec = expQ.pop_front();
                  if ({tr_kind, tr_payload} !== expRec) begin
                     errors++;
                     $display("FAIL record: got %h want %h",
                              {tr_kind, tr_payload}, expRec);
                  end
               end
            end else begin
               stalled = 1;
               held = {tr_kind, tr_payload};
            end
         end
      end
   end

   function automatic logic [55:0] evPay(input logic rw, input logic [2:0] wr,
                                         input logic [15:0] wd, input logic mr,
                                         input logic mw, input logic [15:0] ma,
                                         input logic [15:0] di,
                                         input logic [15:0] dout, input logic h);
      logic [55:0] p;
      p = '0;
      p[55] = rw;
      p[54] = mr;
      p[53] = mw;
      p[52] = h;
      if (rw) begin
         p[50:48] = wr;
         p[47:32] = wd;
      end
      if (mr || mw) p[31:16] = ma;
      if (mw) p[15:0] = di;
      else if (mr) p[15:0] = dout;
      return p;
   endfunction

   // cache = {icreq, ichit, dcreq, dchit}; drop marks a record the bench
   // knows cannot fit into a full buffer.
   task automatic evCycle(input logic rw, input logic [2:0] wr,
                          input logic [15:0] wd, input logic mr, input logic mw,
                          input logic [15:0] ma, input logic [15:0] di,
                          input logic [15:0] dout, input logic h,
                          input logic [3:0] cache, input bit drop);
      logic [31:0] v [7];
      ev_regwrite = rw;
      ev_wreg = wr;
      ev_wdata = wd;
      ev_memread = mr;
      ev_memwrite = mw;
      ev_maddr = ma;
      ev_mdin = di;
      ev_mdout = dout;
      ev_halt = h;
      {ev_icreq, ev_ichit, ev_dcreq, ev_dchit} = cache;
      if (mRun) begin
         mCycle++;
         if (rw | mw | h) mInst++;
         if (cache[3]) mIcReq++;
         if (cache[2]) mIcHit++;
         if (cache[1]) mDcReq++;
         if (cache[0]) mDcHit++;
         if (rw | mr | mw | h) begin
            if (drop) mDrop++;
            else expQ.push_back({1'b0, evPay(rw, wr, wd, mr, mw, ma, di, dout, h)});
         end
         if (h) begin
            mRun = 0;
            v = '{mCycle, mInst, mIcReq, mIcHit, mDcReq, mDcHit, mDrop};
            for (int i = 0; i < 7; i++)
               expQ.push_back({1'b1, 5'b0, 3'(i), 16'b0, v[i]});
         end
      end
      @(posedge clk);
      #1;
      ev_regwrite = 1'b0;
      ev_memread = 1'b0;
      ev_memwrite = 1'b0;
      ev_halt = 1'b0;
      {ev_icreq, ev_ichit, ev_dcreq, ev_dchit} = 4'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         evCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0, 0);
   endtask

   task automatic regw(input logic [2:0] wr, input logic [15:0] wd,
                       input logic [3:0] cache);
      evCycle(1, wr, wd, 0, 0, 0, 0, 0, 0, cache, 0);
   endtask

   task automatic halt(input logic [3:0] cache);
      evCycle(0, 0, 0, 0, 0, 0, 0, 0, 1, cache, 0);
   endtask

   task automatic modelClear();
      expQ.delete();
      mCycle = 0; mInst = 0; mIcReq = 0; mIcHit = 0;
      mDcReq = 0; mDcHit = 0; mDrop = 0;
      mRun = 1;
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      tr_ready = 1'b0;
      modelClear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic waitDone(input string name);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s done: got %b want 1 (timeout)", name, done);
      end
      checks++;
      if (tr_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s valid_at_done: got %b want 0", name, tr_valid);
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL %s pending: got %0d left want 0", name, expQ.size());
      end
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      modelClear();
      #1;
      checks += 5;
      if (tr_valid !== 1'b0) begin
         errors++; $display("FAIL rst_valid: got %b want 0", tr_valid);
      end
      if (tr_kind !== 1'b0) begin
         errors++; $display("FAIL rst_kind: got %b want 0", tr_kind);
      end
      if (tr_payload !== 56'h0) begin
         errors++; $display("FAIL rst_payload: got %h want 0", tr_payload);
      end
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL rst_overflow: got %b want 0", overflow);
      end
      if (done !== 1'b0) begin
         errors++; $display("FAIL rst_done: got %b want 0", done);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      tr_ready = 1'b1;
      regw(3'd3, 16'h1234, 4'b0);
      checks++;
      if (tr_valid !== 1'b1) begin
         errors++; $display("FAIL latency: got valid=%b want 1", tr_valid);
      end
      idle(2);
      checks++;
      if (expQ.size() != 0) begin
         errors++; $display("FAIL single_pending: got %0d want 0", expQ.size());
      end
   endtask

   task automatic test_store_stall();
      logic pat [6] = '{0, 1, 0, 0, 1, 1};
      tr_ready = 1'b0;
      evCycle(0, 0, 0, 0, 1, 16'h0040, 16'hBEEF, 16'h5555, 0, 4'b0, 0);
      evCycle(0, 0, 0, 1, 0, 16'h0080, 16'h7777, 16'h1111, 0, 4'b0100, 0);
      idle(2);
      for (int i = 0; i < 6; i++) begin
         tr_ready = pat[i];
         idle(1);
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++; $display("FAIL stall_pending: got %0d want 0", expQ.size());
      end
   endtask

   task automatic test_overflow();
      doReset();
      for (int i = 0; i < 9; i++)
         evCycle(1, 3'(i), 16'hA000 + 16'(i), 0, 0, 0, 0, 0, 0, 4'b0, i == 8);
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL overflow_set: got %b want 1", overflow);
      end
      tr_ready = 1'b1;
      idle(10);
      checks += 2;
      if (expQ.size() != 0) begin
         errors++; $display("FAIL held_count: got %0d left want 0", expQ.size());
      end
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL overflow_sticky: got %b want 1", overflow);
      end
      halt(4'b0011);
      waitDone("overflow");
   endtask

   task automatic test_summary();
      doReset();
      tr_ready = 1'b1;
      regw(3'd1, 16'h0101, 4'b0);
      idle(0);
      evCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 0);
      idle(1);
      regw(3'd2, 16'h0202, 4'b1100);
      idle(4);
      regw(3'd7, 16'hFFFF, 4'b0);
      halt(4'b0);
      waitDone("summary");
      idle(3);
      checks += 2;
      if (done !== 1'b1) begin
         errors++; $display("FAIL done_sticky: got %b want 1", done);
      end
      if (tr_valid !== 1'b0) begin
         errors++; $display("FAIL done_valid: got %b want 0", tr_valid);
      end
   endtask

   task automatic test_after_halt();
      doReset();
      tr_ready = 1'b0;
      regw(3'd5, 16'h5A5A, 4'b0);
      halt(4'b1000);
      regw(3'd6, 16'h6666, 4'b1111);
      evCycle(0, 0, 0, 0, 1, 16'h0010, 16'h1010, 0, 0, 4'b1010, 0);
      evCycle(1, 3'd1, 16'h1111, 1, 0, 16'h0020, 0, 16'h2020, 1, 4'b0101, 0);
      tr_ready = 1'b1;
      waitDone("after_halt");
   endtask

   task automatic test_reset_summary();
      int n;
      doReset();
      tr_ready = 1'b1;
      halt(4'b0011);
      n = 0;
      while (!(tr_valid === 1'b1 && tr_kind === 1'b1 &&
               tr_payload[50:48] == 3'd3) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      tr_ready = 1'b0;
      checks++;
      if (n >= 50) begin
         errors++; $display("FAIL reach_idx3: got timeout want summary 3");
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks += 2;
      if (tr_valid !== 1'b0) begin
         errors++; $display("FAIL midsum_valid: got %b want 0", tr_valid);
      end
      if (done !== 1'b0) begin
         errors++; $display("FAIL midsum_done: got %b want 0", done);
      end
      modelClear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tr_ready = 1'b1;
      idle(2);
      halt(4'b0);
      waitDone("post_reset");
   endtask

   initial begin
      modelClear();
      test_reset();
      test_single();
      test_store_stall();
      test_overflow();
      test_summary();
      test_after_halt();
      test_reset_summary();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
